// File: rtl/fa_bist.sv
// Built-in self test for a 1-bit full adder: walks all 8 {a,b,cin} vectors and records mismatches.
// Define FA_BIST_STOP_ON_FAIL_EN to end a run at the first mismatching vector.
module fa_bist #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a,
  output logic       b,
  output logic       cin,
  input  logic       sum,
  input  logic       carry_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [7:0] fail_vec
);

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

`ifdef FA_BIST_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state, state_d;
  logic [2:0] idx, idx_d;
  logic [3:0] cnt, cnt_d;
  logic [2:0] vec, vec_d;
  logic       pass_d;
  logic [3:0] err_d;
  logic [7:0] fv_d;
  logic [1:0] expected;
  logic       mismatch;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v >= 4'd8) ? 4'd8 : v + 4'd1;
  endfunction

  assign a    = vec[2];
  assign b    = vec[1];
  assign cin  = vec[0];
  assign busy = (state == DRIVE) || (state == CHECK);
  assign done = (state == DONE);

  // The vector stays on a/b/cin through CHECK so the adder response is still valid when sampled.
  assign expected = {1'b0, vec[2]} + {1'b0, vec[1]} + {1'b0, vec[0]};
  assign mismatch = ({carry_out, sum} != expected);

  always_comb begin
    state_d = state;
    idx_d   = idx;
    cnt_d   = cnt;
    vec_d   = vec;
    pass_d  = pass;
    err_d   = err_count;
    fv_d    = fail_vec;
    case (state)
      IDLE: begin
        if (start) begin
          state_d = DRIVE;
          idx_d   = 3'd0;
          cnt_d   = 4'd0;
          vec_d   = 3'd0;
          pass_d  = 1'b0;
          err_d   = 4'd0;
          fv_d    = 8'h00;
        end
      end
      DRIVE: begin
        if (cnt == SETTLE_LAST) begin
          state_d = CHECK;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt + 4'd1;
        end
      end
      CHECK: begin
        if (mismatch) begin
          err_d     = sat_inc(err_count);
          fv_d[idx] = 1'b1;
        end
        // pass is registered on entry to DONE so it is already valid alongside done
        if (idx == 3'd7 || (STOP_ON_FAIL && mismatch)) begin
          state_d = DONE;
          vec_d   = 3'd0;
          pass_d  = (err_d == 4'd0);
        end else begin
          state_d = DRIVE;
          idx_d   = idx + 3'd1;
          vec_d   = idx + 3'd1;
          cnt_d   = 4'd0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= 3'd0;
      cnt       <= 4'd0;
      vec       <= 3'd0;
      pass      <= 1'b0;
      err_count <= 4'd0;
      fail_vec  <= 8'h00;
    end else begin
      state     <= state_d;
      idx       <= idx_d;
      cnt       <= cnt_d;
      vec       <= vec_d;
      pass      <= pass_d;
      err_count <= err_d;
      fail_vec  <= fv_d;
    end
  end

endmodule

// File: tb/tb_fa_bist.sv
// Directed bench for fa_bist: ideal and faulty adder models, mid-run reset, back-to-back runs, long settle.
module tb_fa_bist;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       a, b, cin, sum, carry_out, busy, done, pass;
  logic [3:0] err_count;
  logic [7:0] fail_vec;

  logic       start3 = 1'b0;
  logic       a3, b3, cin3, sum3, carry_out3, busy3, done3, pass3;
  logic [3:0] err_count3;
  logic [7:0] fail_vec3;

  int fault = 0;
  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;

  logic [1:0] add_res, add_res3;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // adder model: 0 ideal, 1 sum stuck at 0, 2 carry stuck at 1
  assign add_res    = {1'b0, a} + {1'b0, b} + {1'b0, cin};
  assign sum        = (fault == 1) ? 1'b0 : add_res[0];
  assign carry_out  = (fault == 2) ? 1'b1 : add_res[1];
  assign add_res3   = {1'b0, a3} + {1'b0, b3} + {1'b0, cin3};
  assign sum3       = add_res3[0];
  assign carry_out3 = add_res3[1];

  fa_bist #(.SETTLE_CYCLES(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .sum(sum), .carry_out(carry_out), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_vec(fail_vec)
  );

  fa_bist #(.SETTLE_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3), .cin(cin3),
    .sum(sum3), .carry_out(carry_out3), .busy(busy3), .done(done3), .pass(pass3),
    .err_count(err_count3), .fail_vec(fail_vec3)
  );

  // one-cycle start pulse, then wait (bounded) for done; lat is done cycle minus start cycle
  task automatic run(output int lat, output bit got);
    int t0;
    @(posedge clk); #1;
    start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    got = 1'b0;
    lat = -1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        lat = cyc - t0;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_chk++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
    n_chk++; if (pass !== 1'b0) $display("FAIL reset_pass got %b want 0", pass); else n_pass++;
    n_chk++; if (err_count !== 4'd0) $display("FAIL reset_err got %0d want 0", err_count); else n_pass++;
    n_chk++; if (fail_vec !== 8'h00) $display("FAIL reset_fvec got %h want 00", fail_vec); else n_pass++;
    n_chk++; if ({a, b, cin} !== 3'b000) $display("FAIL reset_abc got %b want 000", {a, b, cin}); else n_pass++;
  endtask

  task automatic test_ideal();
    int lat; bit got;
    fault = 0;
    run(lat, got);
    n_chk++; if (!got) $display("FAIL ideal_timeout no done within bound"); else n_pass++;
    n_chk++; if (lat !== 17) $display("FAIL ideal_latency got %0d want 17", lat); else n_pass++;
    n_chk++; if (pass !== 1'b1) $display("FAIL ideal_pass got %b want 1", pass); else n_pass++;
    n_chk++; if (err_count !== 4'd0) $display("FAIL ideal_err got %0d want 0", err_count); else n_pass++;
    n_chk++; if (fail_vec !== 8'h00) $display("FAIL ideal_fvec got %h want 00", fail_vec); else n_pass++;
    n_chk++; if ({a, b, cin, busy} !== 4'b0000) $display("FAIL ideal_done_outs got %b want 0000", {a, b, cin, busy}); else n_pass++;
    @(negedge clk);
    n_chk++; if (done !== 1'b0) $display("FAIL ideal_done_width got %b want 0", done); else n_pass++;
    n_chk++; if (pass !== 1'b1) $display("FAIL ideal_pass_hold got %b want 1", pass); else n_pass++;
  endtask

  task automatic test_sum_stuck();
    int lat; bit got;
    int exp_lat; logic [3:0] exp_err; logic [7:0] exp_fv;
`ifdef FA_BIST_STOP_ON_FAIL_EN
    exp_lat = 5; exp_err = 4'd1; exp_fv = 8'h02;
`else
    exp_lat = 17; exp_err = 4'd4; exp_fv = 8'h96;
`endif
    fault = 1;
    run(lat, got);
    n_chk++; if (lat !== exp_lat) $display("FAIL sum0_latency got %0d want %0d", lat, exp_lat); else n_pass++;
    n_chk++; if (pass !== 1'b0) $display("FAIL sum0_pass got %b want 0", pass); else n_pass++;
    n_chk++; if (err_count !== exp_err) $display("FAIL sum0_err got %0d want %0d", err_count, exp_err); else n_pass++;
    n_chk++; if (fail_vec !== exp_fv) $display("FAIL sum0_fvec got %h want %h", fail_vec, exp_fv); else n_pass++;
    repeat (3) @(negedge clk);
    n_chk++; if ({err_count, fail_vec} !== {exp_err, exp_fv}) $display("FAIL sum0_stable got %h want %h", {err_count, fail_vec}, {exp_err, exp_fv}); else n_pass++;
    fault = 0;
  endtask

  task automatic test_carry_stuck();
    int lat; bit got;
    int exp_lat; logic [3:0] exp_err; logic [7:0] exp_fv;
`ifdef FA_BIST_STOP_ON_FAIL_EN
    exp_lat = 3; exp_err = 4'd1; exp_fv = 8'h01;
`else
    exp_lat = 17; exp_err = 4'd4; exp_fv = 8'h17;
`endif
    fault = 2;
    run(lat, got);
    n_chk++; if (lat !== exp_lat) $display("FAIL cout1_latency got %0d want %0d", lat, exp_lat); else n_pass++;
    n_chk++; if (pass !== 1'b0) $display("FAIL cout1_pass got %b want 0", pass); else n_pass++;
    n_chk++; if (err_count !== exp_err) $display("FAIL cout1_err got %0d want %0d", err_count, exp_err); else n_pass++;
    n_chk++; if (fail_vec !== exp_fv) $display("FAIL cout1_fvec got %h want %h", fail_vec, exp_fv); else n_pass++;
    fault = 0;
  endtask

  task automatic test_reset_midrun();
    bit seen; int ndone; int lat; bit got;
`ifdef FA_BIST_STOP_ON_FAIL_EN
    fault = 0;
`else
    fault = 1;
`endif
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if ({a, b, cin} === 3'b011) seen = 1'b1;
    end
    n_chk++; if (!seen) $display("FAIL midrun_reach_idx3 got 0 want 1"); else n_pass++;
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    n_chk++; if (busy !== 1'b0) $display("FAIL midrun_busy got %b want 0", busy); else n_pass++;
    n_chk++; if ({a, b, cin} !== 3'b000) $display("FAIL midrun_abc got %b want 000", {a, b, cin}); else n_pass++;
    n_chk++; if ({err_count, fail_vec} !== 12'h000) $display("FAIL midrun_results got %h want 000", {err_count, fail_vec}); else n_pass++;
    ndone = 0;
    for (int i = 0; i < 25; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    n_chk++; if (ndone !== 0) $display("FAIL midrun_no_done got %0d want 0", ndone); else n_pass++;
    fault = 0;
    run(lat, got);
    n_chk++; if (lat !== 17) $display("FAIL midrun_rerun_latency got %0d want 17", lat); else n_pass++;
    n_chk++; if (pass !== 1'b1) $display("FAIL midrun_rerun_pass got %b want 1", pass); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int dcyc[3]; int nd;
    fault = 0;
    @(posedge clk); #1 start = 1'b1;
    nd = 0;
    for (int i = 0; i < 120 && nd < 3; i++) begin
      @(negedge clk);
      if (done) begin
        dcyc[nd] = cyc;
        nd++;
      end
    end
    start = 1'b0;
    n_chk++; if (nd !== 3) $display("FAIL b2b_pulses got %0d want 3", nd); else n_pass++;
    n_chk++; if (dcyc[1] - dcyc[0] !== 18) $display("FAIL b2b_gap1 got %0d want 18", dcyc[1] - dcyc[0]); else n_pass++;
    n_chk++; if (dcyc[2] - dcyc[1] !== 18) $display("FAIL b2b_gap2 got %0d want 18", dcyc[2] - dcyc[1]); else n_pass++;
    repeat (3) @(negedge clk);
    n_chk++; if (busy !== 1'b0) $display("FAIL b2b_idle_after got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_start_while_busy();
    int nd;
    fault = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    nd = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (i == 4 || i == 10 || i == 15) start = 1'b1;
      else start = 1'b0;
      if (done) nd++;
    end
    start = 1'b0;
    n_chk++; if (nd !== 1) $display("FAIL busy_start_runs got %0d want 1", nd); else n_pass++;
  endtask

  task automatic test_settle3();
    logic [2:0] trace[40];
    int t0; int lat; bit got; int bad;
    @(posedge clk); #1 start3 = 1'b1;
    t0 = cyc;
    @(posedge clk); #1 start3 = 1'b0;
    got = 1'b0; lat = -1;
    for (int i = 0; i < 80 && !got; i++) begin
      @(negedge clk);
      if (cyc - t0 < 40) trace[cyc - t0] = {a3, b3, cin3};
      if (done3) begin
        got = 1'b1;
        lat = cyc - t0;
      end
    end
    n_chk++; if (lat !== 33) $display("FAIL settle3_latency got %0d want 33", lat); else n_pass++;
    n_chk++; if (pass3 !== 1'b1) $display("FAIL settle3_pass got %b want 1", pass3); else n_pass++;
    for (int v = 0; v < 8; v++) begin
      bad = 0;
      for (int k = 0; k < 3; k++)
        if (trace[1 + 4 * v + k] !== 3'(v)) bad++;
      n_chk++; if (bad !== 0) $display("FAIL settle3_hold_vec%0d got %0d bad cycles want 0", v, bad); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_sum_stuck();
    test_carry_stuck();
    test_reset_midrun();
    test_back_to_back();
    test_start_while_busy();
    test_settle3();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
